// File: rtl/prog_loader.sv
// Serial program loader: receives a counted, checksummed 18-bit word image
// over a byte stream, writes it to program memory and releases the CPU on success.
module prog_loader #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [9:0]  mem_addr,
  output logic [17:0] mem_wdata,
  output logic [3:0]  mem_we,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned AW = 11;
  localparam int unsigned NW = 16;
  localparam int unsigned DW = 18;

  typedef enum logic [3:0] {
    IDLE, HDR_HI, HDR_LO, B0, B1, B2, WRITE, CHK, DONE, ERR
  } state_t;

  state_t          state, state_d;
  logic [AW-1:0]   addr, addr_d, addr_inc;
  logic [DW-1:0]   wdata, wdata_d;
  logic [NW-1:0]   nwords, nwords_d, hdr_n;
  logic [7:0]      csum, csum_d;
  logic [15:0]     to_cnt, to_d, to_inc;
  logic [1:0]      rst_sync;
  logic            run;
  logic            acc;

  // Reset assertion is immediate; release reaches the FSM two clocks later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run = rst_sync[1];

  function automatic logic is_recv(input state_t s);
    return (s == HDR_HI) || (s == HDR_LO) || (s == B0) ||
           (s == B1) || (s == B2) || (s == CHK);
  endfunction

  // rx_ready mirrors the current state, so it qualifies the handshake directly.
  assign acc      = rx_valid & rx_ready;
  assign hdr_n    = {nwords[15:8], rx_data};
  assign addr_inc = addr + AW'(1);
  assign to_inc   = to_cnt + 16'd1;

  always_comb begin
    state_d  = state;
    addr_d   = addr;
    wdata_d  = wdata;
    nwords_d = nwords;
    csum_d   = csum;
    to_d     = to_cnt;

    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = HDR_HI;
          addr_d  = '0;
          csum_d  = '0;
          to_d    = '0;
        end
      end
      HDR_HI: if (acc) begin
        nwords_d = {rx_data, 8'h00};
        state_d  = HDR_LO;
      end
      HDR_LO: if (acc) begin
        nwords_d = hdr_n;
        if (32'(hdr_n) > DEPTH)  state_d = ERR;
        else if (hdr_n == '0)    state_d = CHK;
        else                     state_d = B0;
      end
      B0: if (acc) begin
        wdata_d = {rx_data[1:0], wdata[15:0]};
        state_d = B1;
      end
      B1: if (acc) begin
        wdata_d = {wdata[17:16], rx_data, wdata[7:0]};
        state_d = B2;
      end
      B2: if (acc) begin
        wdata_d = {wdata[17:8], rx_data};
        state_d = WRITE;
      end
      WRITE: begin
        addr_d  = addr_inc;
        state_d = (NW'(addr_inc) == nwords) ? CHK : B0;
      end
      CHK: if (acc) begin
        state_d = (rx_data == csum) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase

    // Running checksum and inter-byte idle timer for every receive state.
    if (is_recv(state)) begin
      if (acc) begin
        if (state != CHK) csum_d = csum ^ rx_data;
        to_d = '0;
      end else begin
        to_d = to_inc;
        if (to_inc == TIMEOUT) state_d = ERR;
      end
    end

    if (!run) begin
      state_d  = IDLE;
      addr_d   = '0;
      wdata_d  = '0;
      nwords_d = '0;
      csum_d   = '0;
      to_d     = '0;
    end
  end

  // State, datapath and outputs; outputs are decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr      <= '0;
      wdata     <= '0;
      nwords    <= '0;
      csum      <= '0;
      to_cnt    <= '0;
      rx_ready  <= 1'b0;
      mem_we    <= 4'b0000;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_d;
      addr      <= addr_d;
      wdata     <= wdata_d;
      nwords    <= nwords_d;
      csum      <= csum_d;
      to_cnt    <= to_d;
      rx_ready  <= is_recv(state_d);
      mem_we    <= (state_d == WRITE) ? 4'b1111 : 4'b0000;
      cpu_reset <= (state_d != DONE);
      busy      <= !((state_d == IDLE) || (state_d == DONE) || (state_d == ERR));
      done      <= (state_d == DONE);
      error     <= (state_d == ERR);
    end
  end

  assign mem_addr  = addr[9:0];
  assign mem_wdata = wdata;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: normal loads, checksum/size errors,
// idle timeout, ignored start and reset mid-load.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [9:0]  mem_addr;
  logic [17:0] mem_wdata;
  logic [3:0]  mem_we;
  logic        cpu_reset, busy, done, error;

  int vectors = 0;
  int miscompares = 0;
  int base;

  int          nw = 0;
  logic [9:0]  wa [0:63];
  logic [17:0] wd [0:63];
  logic [3:0]  wm [0:63];

  always #5 clk = ~clk;

  prog_loader #(.DEPTH(1024), .TIMEOUT(16'd20)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  // Log every memory write cycle.
  always @(negedge clk) begin
    if (mem_we != 4'b0000) begin
      if (nw < 64) begin
        wa[6'(nw)] <= mem_addr;
        wd[6'(nw)] <= mem_wdata;
        wm[6'(nw)] <= mem_we;
      end
      nw <= nw + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      vectors++;
      miscompares++;
      $display("FAIL rx_ready wait: observed no ready for byte %0h, required ready within 40 cycles", b);
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst mem_we",    32'(mem_we), 32'(0));
    chk("rst rx_ready",  32'(rx_ready), 32'(0));
    chk("rst busy",      32'(busy), 32'(0));
    chk("rst done",      32'(done), 32'(0));
    chk("rst error",     32'(error), 32'(0));
    chk("rst cpu_reset", 32'(cpu_reset), 32'(1));
    chk("rst mem_addr",  32'(mem_addr), 32'(0));
    chk("rst mem_wdata", 32'(mem_wdata), 32'(0));
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle cpu_reset", 32'(cpu_reset), 32'(1));

    // Two-word load; checksum covers header bytes: 00^02^03^C0^02^00^4E^01 = 8C
    base = nw;
    pulse_start();
    chk("A busy", 32'(busy), 32'(1));
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'hC0); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h4E); send_byte(8'h01);
    send_byte(8'h8C);
    chk("A done",      32'(done), 32'(1));
    chk("A error",     32'(error), 32'(0));
    chk("A cpu_reset", 32'(cpu_reset), 32'(0));
    chk("A busy end",  32'(busy), 32'(0));
    chk("A writes",    32'(nw - base), 32'(2));
    chk("A addr0",     32'(wa[6'(base)]), 32'(0));
    chk("A data0",     32'(wd[6'(base)]), 32'h3C002);
    chk("A we0",       32'(wm[6'(base)]), 32'hF);
    chk("A addr1",     32'(wa[6'(base + 1)]), 32'(1));
    chk("A data1",     32'(wd[6'(base + 1)]), 32'h04E01);

    // Bad checksum, with a start pulse mid-load that must be ignored
    base = nw;
    pulse_start();
    chk("B cpu_reset", 32'(cpu_reset), 32'(1));
    chk("B done clr",  32'(done), 32'(0));
    send_byte(8'h00); send_byte(8'h02);
    pulse_start();
    chk("B busy", 32'(busy), 32'(1));
    send_byte(8'h03); send_byte(8'hC0); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h4E); send_byte(8'h01);
    send_byte(8'h8D);
    chk("B error",     32'(error), 32'(1));
    chk("B done",      32'(done), 32'(0));
    chk("B cpu_reset", 32'(cpu_reset), 32'(1));
    chk("B writes",    32'(nw - base), 32'(2));
    chk("B data1",     32'(wd[6'(base + 1)]), 32'h04E01);

    // Oversize header N = 1025
    base = nw;
    pulse_start();
    chk("C error clr", 32'(error), 32'(0));
    send_byte(8'h04); send_byte(8'h01);
    chk("C error",    32'(error), 32'(1));
    chk("C rx_ready", 32'(rx_ready), 32'(0));
    repeat (3) @(negedge clk);
    chk("C writes",   32'(nw - base), 32'(0));

    // Empty image, good then bad checksum
    base = nw;
    pulse_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("D0 done",  32'(done), 32'(1));
    pulse_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    chk("D1 error", 32'(error), 32'(1));
    chk("D writes", 32'(nw - base), 32'(0));

    // Idle timeout while waiting for B2 (TIMEOUT = 20)
    base = nw;
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h03); send_byte(8'hC0);
    repeat (19) @(posedge clk);
    #1 chk("E busy before timeout", 32'(busy), 32'(1));
    @(posedge clk);
    #1 chk("E error at timeout", 32'(error), 32'(1));
    chk("E writes", 32'(nw - base), 32'(0));

    // Recovery; B0 upper bits ignored for data but counted in checksum:
    // 00^01^FD^23^45 = 9A
    base = nw;
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hFD); send_byte(8'h23); send_byte(8'h45);
    send_byte(8'h9A);
    chk("E2 done",   32'(done), 32'(1));
    chk("E2 writes", 32'(nw - base), 32'(1));
    chk("E2 data",   32'(wd[6'(base)]), 32'h12345);

    // Reset between B1 and B2 of word 5
    base = nw;
    pulse_start();
    send_byte(8'h00); send_byte(8'h06);
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h00); send_byte(8'h00); send_byte(8'(i + 1));
    end
    send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("F mem_we",    32'(mem_we), 32'(0));
    chk("F busy",      32'(busy), 32'(0));
    chk("F rx_ready",  32'(rx_ready), 32'(0));
    chk("F cpu_reset", 32'(cpu_reset), 32'(1));
    chk("F mem_addr",  32'(mem_addr), 32'(0));
    chk("F mem_wdata", 32'(mem_wdata), 32'(0));
    repeat (4) @(negedge clk);
    chk("F writes",    32'(nw - base), 32'(5));
    chk("F last addr", 32'(wa[6'(base + 4)]), 32'(4));
    chk("F last data", 32'(wd[6'(base + 4)]), 32'h00005);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    pulse_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("F recover done", 32'(done), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
